// File: rtl/isqrt_pipelined.sv
// isqrt_pipelined
//   Fully pipelined integer square root: y = floor(sqrt(x)) for a 32-bit unsigned
//   radicand. It uses the restoring digit-by-digit method, so there are no multipliers.
//   Each pipeline stage resolves ITERS_PER_STAGE root bits, which gives a latency of
//   16/ITERS_PER_STAGE cycles. A new argument is accepted every cycle. There is no
//   backpressure, and results leave in issue order.
//
// Parameters
//   ITERS_PER_STAGE  root bits resolved per stage; legal values 1, 2, 4, 8, 16
//
// Ports
//   clk    in   1   clock, all state on posedge
//   rst    in   1   synchronous, active-high reset; clears only the valid chain
//   x_vld  in   1   argument valid; x is sampled whenever x_vld=1
//   x      in   32  unsigned radicand
//   y_vld  out  1   result valid, one pulse per accepted argument
//   y      out  16  floor(sqrt(x)) of the matching argument; don't-care while y_vld=0

module isqrt_pipelined #(
  parameter int ITERS_PER_STAGE = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        x_vld,
  input  logic [31:0] x,
  output logic        y_vld,
  output logic [15:0] y
);

  localparam int IPS     = ITERS_PER_STAGE;
  localparam int LATENCY = 16 / IPS;

  genvar s;
  generate
    for (s = 0; s < LATENCY; s++) begin : g_stage
      logic [33:0] rem_in, rem_c, rem_sh, trial, rem_q;
      logic [15:0] root_in, root_c, root_q;
      logic [31:0] xs_in, xs_c, xs_q;
      logic        vld_in, vld_q;

      // Stage 0 is fed straight from the ports with an empty remainder and root.
      // There is no input register.
      if (s == 0) begin : g_first
        assign rem_in  = '0;
        assign root_in = '0;
        assign xs_in   = x;
        assign vld_in  = x_vld;
      end else begin : g_next
        assign rem_in  = g_stage[s-1].rem_q;
        assign root_in = g_stage[s-1].root_q;
        assign xs_in   = g_stage[s-1].xs_q;
        assign vld_in  = g_stage[s-1].vld_q;
      end

      // IPS restoring iterations are chained combinationally.
      // Each iteration brings down the next two radicand bits and tries to append a 1
      // to the root. The 34-bit remainder keeps the compare/subtract free of overflow.
      always_comb begin
        rem_c  = rem_in;
        root_c = root_in;
        xs_c   = xs_in;
        rem_sh = '0;
        trial  = '0;
        for (int i = 0; i < IPS; i++) begin
          rem_sh = {rem_c[31:0], xs_c[31:30]};
          trial  = {16'd0, root_c, 2'b01};
          if (rem_sh >= trial) begin
            rem_c  = rem_sh - trial;
            root_c = {root_c[14:0], 1'b1};
          end else begin
            rem_c  = rem_sh;
            root_c = {root_c[14:0], 1'b0};
          end
          xs_c = {xs_c[29:0], 2'b00};
        end
      end

      // Only the valid bit is reset. This drops every in-flight item and ignores
      // x_vld during rst. The data flops just follow the combinational result.
      always_ff @(posedge clk) begin
        if (rst) begin
          vld_q <= 1'b0;
        end else begin
          vld_q <= vld_in;
        end
        rem_q  <= rem_c;
        root_q <= root_c;
        xs_q   <= xs_c;
      end
    end
  endgenerate

  assign y     = g_stage[LATENCY-1].root_q;
  assign y_vld = g_stage[LATENCY-1].vld_q;

  // Nothing consumes the final remainder and the shifted radicand of the last stage.
  logic unused_tail;
  assign unused_tail = ^{g_stage[LATENCY-1].rem_q, g_stage[LATENCY-1].xs_q};

endmodule

// File: tb/tb_isqrt_pipelined.sv
// tb_isqrt_pipelined
//   Drives one stimulus stream into three instances (IPS = 1, 4, 16). Every accepted
//   argument goes onto a single scoreboard queue with its issue cycle. Each instance has
//   its own read pointer into that queue. The monitor compares both the value and the
//   exact arrival cycle against a reference square root built on $sqrt.

module tb_isqrt_pipelined;

  logic        clk;
  logic        rst;
  logic        x_vld;
  logic [31:0] x;
  logic [2:0]  yv;
  logic [15:0] yy [3];

  typedef struct {
    logic [31:0] x;
    int          cyc;
  } item_t;

  item_t sb[$];
  int    ptr [3];
  int    lat [3];
  int    cyc;
  int    checks;
  int    passes;

  isqrt_pipelined #(.ITERS_PER_STAGE(1)) dut1 (
    .clk(clk), .rst(rst), .x_vld(x_vld), .x(x), .y_vld(yv[0]), .y(yy[0])
  );
  isqrt_pipelined #(.ITERS_PER_STAGE(4)) dut4 (
    .clk(clk), .rst(rst), .x_vld(x_vld), .x(x), .y_vld(yv[1]), .y(yy[1])
  );
  isqrt_pipelined #(.ITERS_PER_STAGE(16)) dut16 (
    .clk(clk), .rst(rst), .x_vld(x_vld), .x(x), .y_vld(yv[2]), .y(yy[2])
  );

  // Free-running clock and a cycle counter that the scoreboard uses for arrival times.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Reference model. It starts from a floating-point estimate, then corrects the result
  // with exact 64-bit integer arithmetic.
  function automatic logic [15:0] isqrt_ref(input logic [31:0] v);
    longint xv;
    longint r;
    real    rv;
    xv = longint'({32'd0, v});
    rv = xv;
    r  = longint'($rtoi($floor($sqrt(rv))));
    while (r * r > xv) r--;
    while ((r + 1) * (r + 1) <= xv) r++;
    return r[15:0];
  endfunction

  // Monitor. Each y_vld pops the instance's next expected item, whose result must arrive
  // exactly lat cycles after issue. An item that is overdue with no y_vld counts as a
  // missing result.
  always @(negedge clk) begin
    for (int j = 0; j < 3; j++) begin
      if (yv[j] === 1'b1) begin
        checks++;
        if (ptr[j] >= sb.size()) begin
          $display("[TB] FAIL unexpected_y_vld ips_dut%0d cyc=%0d got y=%0h, required no output",
                   j, cyc, yy[j]);
        end else begin
          if (yy[j] !== isqrt_ref(sb[ptr[j]].x) || cyc != sb[ptr[j]].cyc + lat[j]) begin
            $display("[TB] FAIL result ips_dut%0d x=%0h got y=%0h at cyc %0d, required y=%0h at cyc %0d",
                     j, sb[ptr[j]].x, yy[j], cyc, isqrt_ref(sb[ptr[j]].x),
                     sb[ptr[j]].cyc + lat[j]);
          end else begin
            passes++;
          end
          ptr[j]++;
        end
      end else if (ptr[j] < sb.size() && sb[ptr[j]].cyc + lat[j] <= cyc) begin
        checks++;
        $display("[TB] FAIL missing_y_vld ips_dut%0d x=%0h got no output by cyc %0d, required at cyc %0d",
                 j, sb[ptr[j]].x, cyc, sb[ptr[j]].cyc + lat[j]);
        ptr[j]++;
      end
    end
  end

  // Drives one cycle of input, then advances to just after the next posedge.
  task automatic issue(input logic v, input logic [31:0] xv);
    item_t it;
    x_vld = v;
    x     = xv;
    if (v && !rst) begin
      it.x   = xv;
      it.cyc = cyc;
      sb.push_back(it);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) issue(1'b0, 32'd0);
  endtask

  task automatic test_reset();
    rst   = 1'b1;
    x_vld = 1'b1;
    x     = 32'h1234_5678;
    repeat (3) @(posedge clk);
    #1;
    for (int j = 0; j < 3; j++) begin
      checks++;
      if (yv[j] !== 1'b0) $display("[TB] FAIL reset_y_vld ips_dut%0d got %b, required 0", j, yv[j]);
      else passes++;
    end
    rst   = 1'b0;
    x_vld = 1'b0;
    idle(2);
  endtask

  task automatic test_single();
    logic [31:0] vals [4];
    vals = '{32'd0, 32'd1, 32'hFFFF_FFFF, 32'hFFFE_0001};
    for (int i = 0; i < 4; i++) begin
      issue(1'b1, vals[i]);
      idle(18);
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] vals [5];
    vals = '{32'd15, 32'd16, 32'd17, 32'd24, 32'd25};
    for (int i = 0; i < 5; i++) issue(1'b1, vals[i]);
    idle(18);
  endtask

  task automatic test_gapped();
    logic        pat  [7];
    logic [31:0] vals [4];
    int          k;
    pat  = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
    vals = '{32'd100, 32'd99, 32'd2, 32'd1000000};
    k = 0;
    for (int i = 0; i < 7; i++) begin
      if (pat[i]) begin
        issue(1'b1, vals[k]);
        k++;
      end else begin
        issue(1'b0, 32'hDEAD_BEEF);
      end
    end
    idle(18);
  endtask

  task automatic test_reset_midflight();
    for (int i = 0; i < 8; i++) issue(1'b1, 32'd1000 + 32'(i) * 32'd7777);
    idle(5);
    rst   = 1'b1;
    x_vld = 1'b1;
    x     = 32'd123;
    @(posedge clk);
    #1;
    // Everything still in flight when rst was sampled is gone, in every instance.
    for (int j = 0; j < 3; j++) begin
      ptr[j] = sb.size();
      checks++;
      if (yv[j] !== 1'b0) $display("[TB] FAIL midflight_reset_y_vld ips_dut%0d got %b, required 0", j, yv[j]);
      else passes++;
    end
    rst = 1'b0;
    issue(1'b1, 32'd49);
    idle(18);
  endtask

  task automatic test_squares();
    longint ks [4];
    longint sq;
    ks = '{64'd1, 64'd255, 64'd256, 64'd65535};
    for (int i = 0; i < 4; i++) begin
      sq = ks[i] * ks[i];
      issue(1'b1, 32'(sq - 1));
      issue(1'b1, 32'(sq));
      issue(1'b1, 32'(sq + 1));
    end
    idle(18);
  endtask

  task automatic test_random();
    int issued;
    int dens;
    logic [31:0] xv;
    issued = 0;
    dens   = 100;
    while (issued < 10000) begin
      if ($urandom_range(0, 199) == 0) dens = $urandom_range(25, 100);
      case ($urandom_range(0, 9))
        0:       xv = 32'hFFFF_FFFF - 32'($urandom_range(0, 3));
        1:       xv = 32'($urandom_range(0, 300));
        default: xv = $urandom;
      endcase
      if ($urandom_range(1, 100) <= dens) begin
        issue(1'b1, xv);
        issued++;
      end else begin
        issue(1'b0, xv);
      end
    end
    idle(20);
  endtask

  task automatic test_drain();
    idle(20);
    for (int j = 0; j < 3; j++) begin
      checks++;
      if (ptr[j] != sb.size())
        $display("[TB] FAIL drain_count ips_dut%0d got %0d results, required %0d", j, ptr[j], sb.size());
      else passes++;
    end
  endtask

  initial begin
    checks = 0;
    passes = 0;
    lat    = '{16, 4, 1};
    ptr    = '{0, 0, 0};
    rst    = 1'b1;
    x_vld  = 1'b0;
    x      = '0;

    test_reset();
    test_single();
    test_back_to_back();
    test_gapped();
    test_reset_midflight();
    test_squares();
    test_random();
    test_drain();

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
